// File: rtl/lockstep_dmem_ctrl.sv
// rtl/lockstep_dmem_ctrl.sv - lockstep data-port comparator and memory gate for two zeroriscy cores
// Forwards matching requests to memory; on divergence it drains, then holds both cores in reset.
module lockstep_dmem_ctrl #(
  parameter int unsigned RST_CYCLES = 8,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             c0_req_i,
  input  logic             c0_we_i,
  input  logic [3:0]       c0_be_i,
  input  logic [31:0]      c0_addr_i,
  input  logic [31:0]      c0_wdata_i,
  input  logic             c1_req_i,
  input  logic             c1_we_i,
  input  logic [3:0]       c1_be_i,
  input  logic [31:0]      c1_addr_i,
  input  logic [31:0]      c1_wdata_i,
  output logic             core_gnt_o,
  output logic             core_rvalid_o,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [3:0]       mem_be_o,
  output logic [31:0]      mem_addr_o,
  output logic [31:0]      mem_wdata_o,
  input  logic             mem_gnt_i,
  input  logic             mem_rvalid_i,
  output logic             core_rst_no,
  output logic             err_o,
  input  logic             err_clr_i,
  output logic [CNT_W-1:0] mismatch_cnt_o,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    RECOVER = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             core_rst_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q;
  logic             pending_q;
  logic [7:0]       rcnt_q;
  logic             mismatch;
  logic             fields_differ;

  // wdata only matters when both cores agree on a write
  assign fields_differ = (c0_we_i != c1_we_i) || (c0_be_i != c1_be_i) ||
                         (c0_addr_i != c1_addr_i) ||
                         (c0_we_i && (c0_wdata_i != c1_wdata_i));

  assign mismatch = (state_q == RUN) && core_rst_q &&
                    ((c0_req_i != c1_req_i) || (c0_req_i && c1_req_i && fields_differ));

  always_comb begin
    state_d   = state_q;
    mem_req_o = 1'b0;
    case (state_q)
      RUN: begin
        mem_req_o = core_rst_q && !mismatch && c0_req_i;
        if (mismatch) state_d = DRAIN;
      end
      DRAIN: begin
        if (!pending_q || mem_rvalid_i) state_d = RECOVER;
      end
      RECOVER: begin
        if (rcnt_q == 8'd0) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= RUN;
      core_rst_q <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      pending_q  <= 1'b0;
      rcnt_q     <= 8'd0;
    end else begin
      state_q    <= state_d;
      core_rst_q <= (state_d != RECOVER);
      if (state_q == DRAIN && state_d == RECOVER) begin
        rcnt_q <= 8'(RST_CYCLES - 1);
      end else if (state_q == RECOVER && rcnt_q != 8'd0) begin
        rcnt_q <= rcnt_q - 8'd1;
      end
      // a new grant in the response cycle keeps the flag set
      pending_q <= (mem_req_o && mem_gnt_i) || (pending_q && !mem_rvalid_i);
      if (mismatch) begin
        err_q <= 1'b1;
      end else if (err_clr_i) begin
        err_q <= 1'b0;
      end
      if (mismatch && cnt_q != {CNT_W{1'b1}}) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign core_gnt_o     = mem_gnt_i && mem_req_o;
  assign core_rvalid_o  = mem_rvalid_i;
  assign mem_we_o       = c0_we_i;
  assign mem_be_o       = c0_be_i;
  assign mem_addr_o     = c0_addr_i;
  assign mem_wdata_o    = c0_wdata_i;
  assign core_rst_no    = core_rst_q;
  assign err_o          = err_q;
  assign mismatch_cnt_o = cnt_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_lockstep_dmem_ctrl.sv
// tb/tb_lockstep_dmem_ctrl.sv - self-checking bench for lockstep_dmem_ctrl
// Expected memory transactions are queued when driven and popped at each memory handshake.
module tb_lockstep_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        c0_req, c0_we, c1_req, c1_we;
  logic [3:0]  c0_be, c1_be;
  logic [31:0] c0_addr, c0_wdata, c1_addr, c1_wdata;
  logic        core_gnt, core_rvalid, mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_gnt, mem_rvalid, core_rst_n, err, err_clr;
  logic [1:0]  cnt;
  logic [1:0]  state;

  int errors = 0;
  int checks = 0;
  logic [68:0] exp_q[$];

  lockstep_dmem_ctrl #(.RST_CYCLES(8), .CNT_W(2)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .c0_req_i(c0_req), .c0_we_i(c0_we), .c0_be_i(c0_be), .c0_addr_i(c0_addr), .c0_wdata_i(c0_wdata),
    .c1_req_i(c1_req), .c1_we_i(c1_we), .c1_be_i(c1_be), .c1_addr_i(c1_addr), .c1_wdata_i(c1_wdata),
    .core_gnt_o(core_gnt), .core_rvalid_o(core_rvalid),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
    .core_rst_no(core_rst_n), .err_o(err), .err_clr_i(err_clr),
    .mismatch_cnt_o(cnt), .state_o(state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  // scoreboard: every memory handshake must match the next queued transaction
  always @(negedge clk) begin
    if (rst_n && mem_req && mem_gnt) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL mem_unexpected: got req we=%0b addr=%h wdata=%h, required no request", mem_we, mem_addr, mem_wdata);
      end else begin
        logic [68:0] e;
        e = exp_q.pop_front();
        if ({mem_we, mem_be, mem_addr, mem_wdata} !== e) begin
          errors++;
          $display("FAIL mem_txn: got %h, required %h", {mem_we, mem_be, mem_addr, mem_wdata}, e);
        end
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_both(input logic req, input logic we, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wdata);
    c0_req = req; c0_we = we; c0_be = be; c0_addr = addr; c0_wdata = wdata;
    c1_req = req; c1_we = we; c1_be = be; c1_addr = addr; c1_wdata = wdata;
  endtask

  task automatic idle();
    set_both(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic wait_recover(output int lows, output bit ok);
    int n;
    lows = 0;
    n = 0;
    while (!(state == 2'd0 && core_rst_n == 1'b1) && n < 50) begin
      if (core_rst_n == 1'b0) lows++;
      cycle();
      n++;
    end
    ok = (n < 50);
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    cycle(); cycle();
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d, required 0", state); end
    checks++; if (core_rst_n !== 1'b0) begin errors++; $display("FAIL reset_core_rst: got %b, required 0", core_rst_n); end
    checks++; if (err !== 1'b0 || cnt !== 2'd0) begin errors++; $display("FAIL reset_err_cnt: got err=%b cnt=%0d, required 0/0", err, cnt); end
    rst_n = 1'b1;
    cycle();
    checks++; if (core_rst_n !== 1'b1) begin errors++; $display("FAIL reset_release: got %b, required 1", core_rst_n); end
  endtask

  task automatic test_matching_read();
    set_both(1'b1, 1'b0, 4'hf, 32'h100, 32'h0);
    mem_gnt = 1'b1;
    exp_q.push_back({1'b0, 4'hf, 32'h100, 32'h0});
    @(negedge clk);
    checks++; if (mem_req !== 1'b1 || core_gnt !== 1'b1) begin errors++; $display("FAIL read_gnt: got req=%b gnt=%b, required 1/1", mem_req, core_gnt); end
    cycle();
    idle();
    mem_rvalid = 1'b1;
    @(negedge clk);
    checks++; if (core_rvalid !== 1'b1) begin errors++; $display("FAIL read_rvalid: got %b, required 1", core_rvalid); end
    cycle();
    mem_rvalid = 1'b0;
    checks++; if (err !== 1'b0 || state !== 2'd0) begin errors++; $display("FAIL read_status: got err=%b state=%0d, required 0/0", err, state); end
  endtask

  task automatic test_write_divergence();
    int lows;
    bit ok;
    set_both(1'b1, 1'b1, 4'hf, 32'h200, 32'hDEADBEEF);
    c1_wdata = 32'hDEADBEEE;
    mem_gnt = 1'b1;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0 || core_gnt !== 1'b0) begin errors++; $display("FAIL wdiv_block: got req=%b gnt=%b, required 0/0", mem_req, core_gnt); end
    cycle();
    idle();
    checks++; if (state !== 2'd1 || err !== 1'b1 || cnt !== 2'd1) begin errors++; $display("FAIL wdiv_flags: got state=%0d err=%b cnt=%0d, required 1/1/1", state, err, cnt); end
    c0_req = 1'b1;  // skewed requests while recovering must be ignored
    wait_recover(lows, ok);
    idle();
    checks++; if (!ok) begin errors++; $display("FAIL wdiv_timeout: got no return to RUN, required RUN"); end
    checks++; if (lows !== 8) begin errors++; $display("FAIL wdiv_rst_len: got %0d low cycles, required 8", lows); end
    checks++; if (cnt !== 2'd1) begin errors++; $display("FAIL wdiv_recover_ignored: got cnt=%0d, required 1", cnt); end
  endtask

  task automatic test_request_skew();
    int lows;
    bit ok;
    idle();
    c0_req = 1'b1; c0_addr = 32'h300;
    mem_gnt = 1'b1;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL skew_block: got %b, required 0", mem_req); end
    cycle();
    idle();
    checks++; if (state !== 2'd1 || cnt !== 2'd2) begin errors++; $display("FAIL skew_flags: got state=%0d cnt=%0d, required 1/2", state, cnt); end
    wait_recover(lows, ok);
    checks++; if (!ok) begin errors++; $display("FAIL skew_timeout: got no return to RUN, required RUN"); end
    set_both(1'b1, 1'b0, 4'hf, 32'h304, 32'h11111111);
    c1_wdata = 32'h22222222;
    mem_gnt = 1'b1;
    exp_q.push_back({1'b0, 4'hf, 32'h304, 32'h11111111});
    @(negedge clk);
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL read_wdata_ignored: got req=%b, required 1", mem_req); end
    cycle();
    idle();
    mem_rvalid = 1'b1;
    checks++; if (state !== 2'd0 || cnt !== 2'd2) begin errors++; $display("FAIL read_wdata_state: got state=%0d cnt=%0d, required 0/2", state, cnt); end
    cycle();
    mem_rvalid = 1'b0;
  endtask

  task automatic test_drain();
    int lows;
    bit ok;
    set_both(1'b1, 1'b0, 4'hf, 32'h400, 32'h0);
    mem_gnt = 1'b1;
    exp_q.push_back({1'b0, 4'hf, 32'h400, 32'h0});
    cycle();
    c0_addr = 32'h404;
    mem_rvalid = 1'b1;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0 || core_gnt !== 1'b0 || core_rvalid !== 1'b1) begin errors++; $display("FAIL drain_entry: got req=%b gnt=%b rvalid=%b, required 0/0/1", mem_req, core_gnt, core_rvalid); end
    cycle();
    idle();
    checks++; if (state !== 2'd1 || cnt !== 2'd3) begin errors++; $display("FAIL drain_state: got state=%0d cnt=%0d, required 1/3", state, cnt); end
    cycle();
    checks++; if (state !== 2'd2 || core_rst_n !== 1'b0) begin errors++; $display("FAIL drain_exit: got state=%0d rst_n=%b, required 2/0", state, core_rst_n); end
    wait_recover(lows, ok);
    checks++; if (!ok) begin errors++; $display("FAIL drain_timeout: got no return to RUN, required RUN"); end
  endtask

  task automatic test_back_to_back();
    int lows;
    bit ok;
    set_both(1'b1, 1'b1, 4'hf, 32'h500, 32'hA5A5A5A5);
    mem_gnt = 1'b1;
    exp_q.push_back({1'b1, 4'hf, 32'h500, 32'hA5A5A5A5});
    cycle();
    set_both(1'b1, 1'b1, 4'hf, 32'h504, 32'h5A5A5A5A);
    mem_rvalid = 1'b1;
    exp_q.push_back({1'b1, 4'hf, 32'h504, 32'h5A5A5A5A});
    @(negedge clk);
    checks++; if (core_gnt !== 1'b1 || core_rvalid !== 1'b1) begin errors++; $display("FAIL b2b_gnt: got gnt=%b rvalid=%b, required 1/1", core_gnt, core_rvalid); end
    cycle();
    set_both(1'b1, 1'b1, 4'hf, 32'h508, 32'h0);
    c1_be = 4'h3;
    mem_rvalid = 1'b0;
    cycle();
    idle();
    cycle();
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL b2b_drain_hold: got state=%0d, required 1", state); end
    mem_rvalid = 1'b1;
    cycle();
    mem_rvalid = 1'b0;
    checks++; if (state !== 2'd2 || cnt !== 2'd3) begin errors++; $display("FAIL b2b_drain_exit: got state=%0d cnt=%0d, required 2/3", state, cnt); end
    wait_recover(lows, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout: got no return to RUN, required RUN"); end
  endtask

  task automatic test_saturation_clear();
    int lows;
    bit ok;
    idle();
    c1_req = 1'b1;
    cycle();
    idle();
    checks++; if (cnt !== 2'd3 || err !== 1'b1) begin errors++; $display("FAIL sat_cnt: got cnt=%0d err=%b, required 3/1", cnt, err); end
    wait_recover(lows, ok);
    checks++; if (!ok) begin errors++; $display("FAIL sat_timeout: got no return to RUN, required RUN"); end
    err_clr = 1'b1;
    cycle();
    err_clr = 1'b0;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clear: got %b, required 0", err); end
    set_both(1'b1, 1'b0, 4'hf, 32'h600, 32'h0);
    c1_addr = 32'h604;
    err_clr = 1'b1;
    cycle();
    idle();
    checks++; if (err !== 1'b1 || state !== 2'd1) begin errors++; $display("FAIL err_set_wins: got err=%b state=%0d, required 1/1", err, state); end
    wait_recover(lows, ok);
    checks++; if (!ok) begin errors++; $display("FAIL clr_timeout: got no return to RUN, required RUN"); end
  endtask

  task automatic test_reset_mid_recover();
    set_both(1'b1, 1'b1, 4'hf, 32'h700, 32'h0);
    c1_we = 1'b0;
    cycle();
    idle();
    repeat (4) cycle();
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL rmr_pre: got state=%0d, required 2", state); end
    rst_n = 1'b0;
    #1;
    checks++; if (state !== 2'd0 || core_rst_n !== 1'b0 || err !== 1'b0 || cnt !== 2'd0) begin errors++; $display("FAIL rmr_async: got state=%0d rst_n=%b err=%b cnt=%0d, required 0/0/0/0", state, core_rst_n, err, cnt); end
    cycle();
    rst_n = 1'b1;
    checks++; if (core_rst_n !== 1'b0) begin errors++; $display("FAIL rmr_held: got %b, required 0", core_rst_n); end
    cycle();
    checks++; if (core_rst_n !== 1'b1 || state !== 2'd0) begin errors++; $display("FAIL rmr_release: got rst_n=%b state=%0d, required 1/0", core_rst_n, state); end
  endtask

  initial begin
    idle();
    test_reset();
    test_matching_read();
    test_write_divergence();
    test_request_skew();
    test_drain();
    test_back_to_back();
    test_saturation_clear();
    test_reset_mid_recover();
    cycle();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d pending transactions, required 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
